// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and defaults for the register-file writeback arbiter.
// Register address/data bus types plus requester count and grant id width.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REQ    = 3;
  localparam int ID_W       = 2;

  typedef logic [REG_ADDR_W-1:0] RegAddressBus;
  typedef logic [REG_DATA_W-1:0] RegBus;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches valid from ptr, wrapping modulo N.
// Ports: valid/ptr in; one-hot grant, grant index and any-valid out.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk from the farthest slot back to ptr so the
  // nearest valid requester is the last one written.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = |valid;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port between writeback
// sources; winner is registered onto write_* one cycle after accept.
// Ports: clk_in, rst_n_in (async low), rdy_in (freeze), req_valid/
// req_ready/req_addr/req_data per requester, write_enable/address/data,
// grant_id. Macro REGFILE_SCOREBOARD_EN adds the busy scoreboard ports
// busy_set_en/busy_set_addr/flush_in/q1_addr/q2_addr/q1_busy/q2_busy.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ID_W    = regfile_wb_arbiter_pkg::ID_W
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_address,
  output logic [DATA_W-1:0]         write_data,
  output logic [ID_W-1:0]           grant_id
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                      busy_set_en,
  input  logic [ADDR_W-1:0]         busy_set_addr,
  input  logic                      flush_in,
  input  logic [ADDR_W-1:0]         q1_addr,
  input  logic [ADDR_W-1:0]         q2_addr,
  output logic                      q1_busy,
  output logic                      q2_busy
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] win_grant;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [ID_W-1:0]    ptr_nxt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign accept    = rdy_in && win_any;
  assign req_ready = rdy_in ? win_grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    int n;
    n = int'(win_idx) + 1;
    if (n >= NUM_REQ) n = 0;
    ptr_nxt = ID_W'(n);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= ptr_nxt;
    end
  end

  // Address 0 is accepted but never strobed into the file.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      grant_id      <= '0;
    end else if (rdy_in) begin
      write_enable <= accept && (sel_addr != '0);
      if (accept) begin
        write_address <= sel_addr;
        write_data    <= sel_data;
        grant_id      <= win_idx;
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Set beats the same-cycle clear; flush beats both.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[write_address] = 1'b0;
    if (busy_set_en && busy_set_addr != '0)
      busy_nxt[busy_set_addr] = 1'b1;
    if (flush_in) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
    end else if (rdy_in) begin
      busy <= busy_nxt;
    end
  end

  // The write retiring this cycle is bypassed so decode
  // does not stall on a register being written right now.
  function automatic logic q_busy(input logic [ADDR_W-1:0] a);
    return rdy_in && (a != '0) && busy[a] &&
           !(write_enable && write_address == a);
  endfunction

  assign q1_busy = q_busy(q1_addr);
  assign q2_busy = q_busy(q2_addr);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter.
// Table of per-cycle inputs/expectations plus reset and scoreboard sequences.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [1:0]  grant_id;
  logic        busy_set_en;
  logic [4:0]  busy_set_addr;
  logic        flush;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;

  regfile_wb_arbiter dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .rdy_in        (rdy),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .grant_id      (grant_id)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .busy_set_en   (busy_set_en),
    .busy_set_addr (busy_set_addr),
    .flush_in      (flush),
    .q1_addr       (q1_addr),
    .q2_addr       (q2_addr),
    .q1_busy       (q1_busy),
    .q2_busy       (q2_busy)
`endif
  );

`ifndef REGFILE_SCOREBOARD_EN
  assign q1_busy = 1'b0;
  assign q2_busy = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  gid;
  } vec_t;

  localparam logic [31:0] D0 = 32'h0000_A5A5;
  localparam logic [31:0] D1 = 32'h0000_B6B6;
  localparam logic [31:0] D2 = 32'h0000_C7C7;
  localparam logic [14:0] A_STD = {5'd7, 5'd6, 5'd5};
  localparam logic [14:0] A_R1Z = {5'd7, 5'd0, 5'd5};
  localparam logic [95:0] D_ALL = {D2, D1, D0};

  int n_vec;
  int n_bad;
  vec_t tbl[15];

  function automatic vec_t mk(
    input logic rd, input logic [2:0] v, input logic [14:0] a,
    input logic [2:0] r, input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [1:0] g);
    vec_t t;
    t.rdy = rd; t.valid = v; t.addr = a; t.data = D_ALL;
    t.ready = r; t.we = we; t.wa = wa; t.wd = wd; t.gid = g;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] g);
    chk({tag, ".we"},  32'(write_enable),  32'(we));
    chk({tag, ".wa"},  32'(write_address), 32'(wa));
    chk({tag, ".wd"},  write_data,         wd);
    chk({tag, ".gid"}, 32'(grant_id),      32'(g));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rdy = 1'b1;
    req_valid = '0;
    req_addr = A_STD;
    req_data = D_ALL;
    busy_set_en = 1'b0;
    busy_set_addr = '0;
    flush = 1'b0;
    q1_addr = '0;
    q2_addr = '0;

    // three-way round robin from reset
    tbl[0]  = mk(1, 3'b111, A_STD, 3'b001, 1, 5'd5, D0, 2'd0);
    tbl[1]  = mk(1, 3'b111, A_STD, 3'b010, 1, 5'd6, D1, 2'd1);
    tbl[2]  = mk(1, 3'b111, A_STD, 3'b100, 1, 5'd7, D2, 2'd2);
    tbl[3]  = mk(1, 3'b111, A_STD, 3'b001, 1, 5'd5, D0, 2'd0);
    tbl[4]  = mk(1, 3'b111, A_STD, 3'b010, 1, 5'd6, D1, 2'd1);
    tbl[5]  = mk(1, 3'b111, A_STD, 3'b100, 1, 5'd7, D2, 2'd2);
    // single req0, then idle: write_enable drops, rest holds
    tbl[6]  = mk(1, 3'b001, A_STD, 3'b001, 1, 5'd5, D0, 2'd0);
    tbl[7]  = mk(1, 3'b000, A_STD, 3'b000, 0, 5'd5, D0, 2'd0);
    // address-0 request accepted but not written
    tbl[8]  = mk(1, 3'b010, A_R1Z, 3'b010, 0, 5'd0, D1, 2'd1);
    // freeze with req2 pending, then accept
    tbl[9]  = mk(0, 3'b100, A_STD, 3'b000, 0, 5'd0, D1, 2'd1);
    tbl[10] = mk(0, 3'b100, A_STD, 3'b000, 0, 5'd0, D1, 2'd1);
    tbl[11] = mk(0, 3'b100, A_STD, 3'b000, 0, 5'd0, D1, 2'd1);
    tbl[12] = mk(1, 3'b100, A_STD, 3'b100, 1, 5'd7, D2, 2'd2);
    // pointer wrap: ptr=0 skips invalid 0, then ptr=2 wraps to 0
    tbl[13] = mk(1, 3'b110, A_STD, 3'b010, 1, 5'd6, D1, 2'd1);
    tbl[14] = mk(1, 3'b011, A_STD, 3'b001, 1, 5'd5, D0, 2'd0);

    #12;
    chk_out("reset", 1'b0, 5'd0, 32'd0, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_reset", 1'b0, 5'd0, 32'd0, 2'd0);

    for (int i = 0; i < 15; i++) begin
      rdy = tbl[i].rdy;
      req_valid = tbl[i].valid;
      req_addr = tbl[i].addr;
      req_data = tbl[i].data;
      #3;
      chk($sformatf("v%0d.ready", i), 32'(req_ready),
          32'(tbl[i].ready));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), tbl[i].we, tbl[i].wa,
              tbl[i].wd, tbl[i].gid);
    end

    // async reset mid-cycle with a write on the outputs
    rdy = 1'b1;
    req_valid = 3'b111;
    req_addr = A_STD;
    @(posedge clk);
    #1;
    chk_out("pre_rst", 1'b1, 5'd6, D1, 2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 5'd0, 32'd0, 2'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_prio.ready", 32'(req_ready), 32'(3'b001));
    @(posedge clk);
    #1;
    chk_out("rst_prio", 1'b1, 5'd5, D0, 2'd0);

`ifdef REGFILE_SCOREBOARD_EN
    req_valid = 3'b000;
    busy_set_en = 1'b1;
    busy_set_addr = 5'd7;
    @(posedge clk);
    #1;
    busy_set_en = 1'b0;
    q1_addr = 5'd7;
    q2_addr = 5'd0;
    #1;
    chk("sb.set_busy", 32'(q1_busy), 32'd1);
    chk("sb.x0_busy", 32'(q2_busy), 32'd0);
    req_valid = 3'b001;
    req_addr = {5'd7, 5'd6, 5'd7};
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    busy_set_en = 1'b1;
    busy_set_addr = 5'd7;
    #1;
    chk("sb.wr_we", 32'(write_enable), 32'd1);
    chk("sb.bypass", 32'(q1_busy), 32'd0);
    @(posedge clk);
    #1;
    busy_set_en = 1'b0;
    #1;
    chk("sb.set_wins", 32'(q1_busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    chk("sb.flush", 32'(q1_busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
